// File: rtl/traffic_light_ctrl_multi.sv
// Round-robin traffic light sequencer for N_DIR approaches: ALL_RED -> GREEN(d) -> YELLOW(d) -> ALL_RED(d+1),
// with flashing-yellow mode, maintenance lamp override and a phase-end strobe. All outputs are registered.
module traffic_light_ctrl_multi #(
  parameter int WIDTH      = 32,
  parameter int N_DIR      = 2,
  parameter int FLASH_HALF = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       maintenance_i,
  input  logic                       flash_i,
  input  logic [N_DIR*WIDTH-1:0]     green_duration_i,
  input  logic [WIDTH-1:0]           yellow_duration_i,
  input  logic [WIDTH-1:0]           red_duration_i,
  input  logic [N_DIR-1:0]           manual_red_i,
  input  logic [N_DIR-1:0]           manual_yellow_i,
  input  logic [N_DIR-1:0]           manual_green_i,
  output logic [N_DIR-1:0]           red_o,
  output logic [N_DIR-1:0]           yellow_o,
  output logic [N_DIR-1:0]           green_o,
  output logic [$clog2(N_DIR)-1:0]   active_dir_o,
  output logic                       phase_end_o
);

  localparam int DW = $clog2(N_DIR);
  localparam int FW = $clog2(2 * FLASH_HALF);

  typedef enum logic [2:0] {
    IDLE,
    ALL_RED,
    GREEN,
    YELLOW,
    FLASH
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     dir_q, dir_d;
  logic [FW-1:0]     flashTimer_q, flashTimer_d;
  logic [N_DIR-1:0]  red_q, red_d;
  logic [N_DIR-1:0]  yellow_q, yellow_d;
  logic [N_DIR-1:0]  green_q, green_d;
  logic              phaseEnd_q, phaseEnd_d;

  logic [WIDTH-1:0]  greenSel;
  logic [DW-1:0]     nextDir;
  logic [N_DIR-1:0]  dirMask;
  logic              expired;

  // A programmed duration of 0 still yields a one-cycle phase.
  function automatic logic [WIDTH-1:0] loadVal(input logic [WIDTH-1:0] dur);
    return (dur == '0) ? '0 : dur - WIDTH'(1);
  endfunction

  assign greenSel = green_duration_i[dir_q*WIDTH +: WIDTH];
  assign nextDir  = (dir_q == DW'(N_DIR - 1)) ? '0 : dir_q + 1'b1;
  assign expired  = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    flashTimer_d = flashTimer_q;
    red_d        = '0;
    yellow_d     = '0;
    green_d      = '0;
    phaseEnd_d   = 1'b0;
    dirMask      = '0;

    if (maintenance_i) begin
      red_d    = manual_red_i;
      yellow_d = manual_yellow_i;
      green_d  = manual_green_i;
    end else if (!start_i) begin
      state_d      = IDLE;
      cnt_d        = '0;
      dir_d        = '0;
      flashTimer_d = '0;
    end else if (flash_i) begin
      state_d = FLASH;
      if (state_q != FLASH) begin
        flashTimer_d = '0;
      end else if (flashTimer_q == FW'(2 * FLASH_HALF - 1)) begin
        flashTimer_d = '0;
      end else begin
        flashTimer_d = flashTimer_q + 1'b1;
      end
      yellow_d = (flashTimer_d < FW'(FLASH_HALF)) ? '1 : '0;
    end else begin
      // Leaving IDLE or FLASH always goes through a full clearance interval first.
      unique case (state_q)
        IDLE, FLASH: begin
          state_d = ALL_RED;
          cnt_d   = loadVal(red_duration_i);
        end
        ALL_RED: begin
          if (expired) begin
            state_d = GREEN;
            cnt_d   = loadVal(greenSel);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        GREEN: begin
          if (expired) begin
            state_d = YELLOW;
            cnt_d   = loadVal(yellow_duration_i);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        YELLOW: begin
          if (expired) begin
            state_d = ALL_RED;
            cnt_d   = loadVal(red_duration_i);
            dir_d   = nextDir;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          dir_d   = '0;
        end
      endcase

      phaseEnd_d = (state_d != IDLE) && (cnt_d == '0);
      dirMask    = N_DIR'(1) << dir_d;

      case (state_d)
        ALL_RED: red_d = '1;
        GREEN: begin
          green_d = dirMask;
          red_d   = ~dirMask;
        end
        YELLOW: begin
          yellow_d = dirMask;
          red_d    = ~dirMask;
        end
        default: red_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dir_q        <= '0;
      flashTimer_q <= '0;
      red_q        <= '0;
      yellow_q     <= '0;
      green_q      <= '0;
      phaseEnd_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      flashTimer_q <= flashTimer_d;
      red_q        <= red_d;
      yellow_q     <= yellow_d;
      green_q      <= green_d;
      phaseEnd_q   <= phaseEnd_d;
    end
  end

  assign red_o        = red_q;
  assign yellow_o     = yellow_q;
  assign green_o      = green_q;
  assign active_dir_o = dir_q;
  assign phase_end_o  = phaseEnd_q;

endmodule
